// File: rtl/mult_kw_seq.sv
// Sequential unsigned K*W x K*W multiplier with a single pipelined W x W core.
// Partial products are issued one per cycle in schoolbook order (i outer,
// j inner). Each one carries its word-shift tag (i+j) down the core pipeline
// and is added into the 2N-bit result register R when it emerges. The
// accumulate mode keeps R instead of clearing it, so successive products sum
// modulo 2^(2N).
//
// Handshake: a request is start=1 sampled on a rising edge while busy=0
// (states IDLE and DONE). On that edge a, b and acc are captured; the inputs
// may change afterwards. busy is high while the operation runs, done pulses
// for exactly one cycle when c holds the result. A start seen while busy=1
// is dropped, not queued. A start during the done cycle begins the next
// operation with no gap.
module mult_kw_seq #(
  parameter int W       = 32,
  parameter int K       = 2,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc,
  input  logic [K*W-1:0]   a,
  input  logic [K*W-1:0]   b,
  output logic [2*K*W-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int N  = K * W;
  // Word index width, shift-tag width (tag max is 2K-2), drain counter width.
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = (K > 1) ? $clog2(2 * K - 1) : 1;
  localparam int DW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic          accept;
  logic          last_pair;
  logic          drain_end;
  logic [IW-1:0] idx_i, idx_j;
  logic [DW-1:0] drain_cnt;
  logic [N-1:0]  a_q, b_q;
  logic [2*N-1:0] r_q;

  // Core input: selected operand words, their product and shift tag.
  logic [W-1:0]   a_w, b_w;
  logic [2*W-1:0] prod;
  logic [TW-1:0]  tag_in;
  logic           issue_v;

  // Core pipeline: data, tag and valid per stage; stage MUL_LAT-1 feeds R.
  logic [2*W-1:0] pipe_p [MUL_LAT];
  logic [TW-1:0]  pipe_t [MUL_LAT];
  logic           pipe_v [MUL_LAT];
  logic [2*N-1:0] addend;

  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_pair = (idx_i == IW'(K - 1)) && (idx_j == IW'(K - 1));
  assign drain_end = (drain_cnt == DW'(MUL_LAT - 1));

  assign a_w     = a_q[idx_i*W +: W];
  assign b_w     = b_q[idx_j*W +: W];
  assign prod    = (2*W)'(a_w) * (2*W)'(b_w);
  assign tag_in  = TW'(idx_i) + TW'(idx_j);
  assign issue_v = (state == S_ISSUE);

  assign addend = (2*N)'(pipe_p[MUL_LAT-1]) << (pipe_t[MUL_LAT-1] * W);

  assign c         = r_q;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: ISSUE for K^2 cycles, DRAIN for MUL_LAT, DONE for one.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (last_pair) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == S_ISSUE) || (state_nxt == S_DRAIN);
      done <= (state_nxt == S_DONE);
    end
  end

  // Word-pair scan counters (j inner) and drain cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_i     <= '0;
      idx_j     <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        idx_i <= '0;
        idx_j <= '0;
      end else if (state == S_ISSUE) begin
        if (idx_j == IW'(K - 1)) begin
          idx_j <= '0;
          idx_i <= idx_i + IW'(1);
        end else begin
          idx_j <= idx_j + IW'(1);
        end
      end
      if (state == S_DRAIN) drain_cnt <= drain_cnt + DW'(1);
      else                  drain_cnt <= '0;
    end
  end

  // Operand capture on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Core pipeline valid bits; cleared on reset so nothing stale reaches R.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MUL_LAT; s++) pipe_v[s] <= 1'b0;
    end else begin
      pipe_v[0] <= issue_v;
      for (int s = 1; s < MUL_LAT; s++) pipe_v[s] <= pipe_v[s-1];
    end
  end

  // Core pipeline data and shift tags.
  always_ff @(posedge clk) begin
    pipe_p[0] <= prod;
    pipe_t[0] <= tag_in;
    for (int s = 1; s < MUL_LAT; s++) begin
      pipe_p[s] <= pipe_p[s-1];
      pipe_t[s] <= pipe_t[s-1];
    end
  end

  // Result register: cleared on a fresh start, otherwise accumulates arrivals.
  // No partial product is in flight when a start is accepted.
  always_ff @(posedge clk) begin
    if (rst)                   r_q <= '0;
    else if (accept && !acc)   r_q <= '0;
    else if (pipe_v[MUL_LAT-1]) r_q <= r_q + addend;
  end

endmodule

// File: tb/tb_mult_kw_seq.sv
// Bench for mult_kw_seq: a default-size instance for directed scenarios and
// a W=16/K=3/MUL_LAT=3 instance for randomized operations. Expected results
// come from plain wide-integer arithmetic on the captured operands.
module tb_mult_kw_seq;

  localparam int W0 = 32, K0 = 2, M0 = 2, N0 = K0 * W0, L0 = K0 * K0 + M0 + 1;
  localparam int W1 = 16, K1 = 3, M1 = 3, N1 = K1 * W1, L1 = K1 * K1 + M1 + 1;

  // Clock and cycle counter.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic           rst0, start0, acc0, busy0, done0;
  logic [N0-1:0]  a0, b0;
  logic [2*N0-1:0] c0;
  logic [1:0]     dbg0;
  logic           rst1, start1, acc1, busy1, done1;
  logic [N1-1:0]  a1, b1;
  logic [2*N1-1:0] c1;
  logic [1:0]     dbg1;

  mult_kw_seq dut0 (
    .clk(clk), .rst(rst0), .start(start0), .acc(acc0), .a(a0), .b(b0),
    .c(c0), .busy(busy0), .done(done0), .dbg_state(dbg0)
  );

  mult_kw_seq #(.W(W1), .K(K1), .MUL_LAT(M1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .acc(acc1), .a(a1), .b(b1),
    .c(c1), .busy(busy1), .done(done1), .dbg_state(dbg1)
  );

  // Scoreboard state: expected results and reference accumulator per instance.
  logic [2*N0-1:0] exp_q0[$];
  logic [2*N1-1:0] exp_q1[$];
  logic [2*N0-1:0] model_r0 = '0;
  logic [2*N1-1:0] model_r1 = '0;
  int last0 = -1000, nf0 = 0;
  int last1 = -1000, nf1 = 0;
  int n_acc1 = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Driver tasks: inputs change on the falling edge; the next rising edge samples them.
  task automatic step0(input logic st, input logic ac, input logic [N0-1:0] av, input logic [N0-1:0] bv);
    @(negedge clk);
    start0 = st; acc0 = ac; a0 = av; b0 = bv;
    if (st && (cyc + 1) >= nf0) begin
      if (ac) model_r0 = model_r0 + (2*N0)'(av) * (2*N0)'(bv);
      else    model_r0 = (2*N0)'(av) * (2*N0)'(bv);
      exp_q0.push_back(model_r0);
      last0 = cyc + 1;
      nf0   = cyc + 1 + L0;
    end
  endtask

  task automatic idle0(input int n);
    repeat (n) step0(1'b0, 1'b0, '0, '0);
  endtask

  task automatic step1(input logic st, input logic ac, input logic [N1-1:0] av, input logic [N1-1:0] bv);
    @(negedge clk);
    start1 = st; acc1 = ac; a1 = av; b1 = bv;
    if (st && (cyc + 1) >= nf1) begin
      if (ac) model_r1 = model_r1 + (2*N1)'(av) * (2*N1)'(bv);
      else    model_r1 = (2*N1)'(av) * (2*N1)'(bv);
      exp_q1.push_back(model_r1);
      last1 = cyc + 1;
      nf1   = cyc + 1 + L1;
      n_acc1++;
    end
  endtask

  task automatic reset0();
    @(negedge clk);
    start0 = 1'b0; rst0 = 1'b1;
    model_r0 = '0; exp_q0.delete(); last0 = -1000; nf0 = 0;
    @(negedge clk);
    rst0 = 1'b0;
  endtask

  // Monitors: sample 1 time unit after the rising edge, check busy/done
  // timing against the last accepted start and pop the scoreboard on done.
  always @(posedge clk) begin
    #1;
    chk("busy0", 128'(busy0), 128'((cyc >= last0) && (cyc <= last0 + L0 - 2)));
    chk("done0", 128'(done0), 128'(cyc == last0 + L0 - 1));
    if (done0) begin
      if (exp_q0.size() == 0) chk("done0_spurious", 128'(1), 128'(0));
      else                    chk("c0", 128'(c0), 128'(exp_q0.pop_front()));
    end
    chk("busy1", 128'(busy1), 128'((cyc >= last1) && (cyc <= last1 + L1 - 2)));
    chk("done1", 128'(done1), 128'(cyc == last1 + L1 - 1));
    if (done1) begin
      if (exp_q1.size() == 0) chk("done1_spurious", 128'(1), 128'(0));
      else                    chk("c1", 128'(c1), 128'(exp_q1.pop_front()));
    end
  end

  task automatic run0();
    logic [N0-1:0] ones;
    ones = '1;
    repeat (3) @(negedge clk);
    chk("rst_c0", 128'(c0), 128'(0));
    chk("rst_busy0", 128'(busy0), 128'(0));
    chk("rst_done0", 128'(done0), 128'(0));
    chk("rst_state0", 128'(dbg0), 128'(0));
    rst0 = 1'b0;
    // Full-scale operands.
    step0(1'b1, 1'b0, ones, ones);
    idle0(8);
    chk("ones_c0", 128'(c0), 128'hFFFFFFFFFFFFFFFE_0000000000000001);
    // Accumulate.
    step0(1'b1, 1'b0, 64'd3, 64'd5);
    idle0(8);
    chk("acc_first", 128'(c0), 128'd15);
    step0(1'b1, 1'b1, ones, 64'd2);
    idle0(8);
    chk("acc_sum", 128'(c0), 128'h2_0000_0000_0000_000D);
    // Wrap: build R = 2^128-1, then add 1*1.
    step0(1'b1, 1'b0, ones, ones);
    idle0(8);
    step0(1'b1, 1'b1, ones, 64'd2);
    idle0(8);
    chk("wrap_max", 128'(c0), {128{1'b1}});
    step0(1'b1, 1'b1, 64'd1, 64'd1);
    idle0(8);
    chk("wrap_zero", 128'(c0), 128'd0);
    // Start held every cycle with changing operands.
    for (int n = 0; n < 40; n++) step0(1'b1, 1'($urandom_range(0, 1)), r64(), r64());
    idle0(10);
    // Edge operands.
    step0(1'b1, 1'b0, 64'd0, r64());
    idle0(8);
    chk("a_zero", 128'(c0), 128'd0);
    step0(1'b1, 1'b0, r64(), 64'd0);
    idle0(8);
    chk("b_zero", 128'(c0), 128'd0);
    step0(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    idle0(8);
    chk("msb_sq", 128'(c0), 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    // Reset arriving at edge t0+3 of a running operation.
    step0(1'b1, 1'b0, r64() | 64'd1, r64() | 64'd1);
    idle0(2);
    reset0();
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_c0", 128'(c0), 128'd0);
      chk("post_rst_busy0", 128'(busy0), 128'd0);
      chk("post_rst_done0", 128'(done0), 128'd0);
    end
    step0(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    idle0(10);
  endtask

  task automatic run1();
    repeat (3) @(negedge clk);
    chk("rst_c1", 128'(c1), 128'(0));
    chk("rst_busy1", 128'(busy1), 128'(0));
    chk("rst_done1", 128'(done1), 128'(0));
    chk("rst_state1", 128'(dbg1), 128'(0));
    rst1 = 1'b0;
    while (n_acc1 < 1000)
      step1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            N1'(r64()), N1'(r64()));
    repeat (L1 + 3) step1(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst0 = 1'b1; start0 = 1'b0; acc0 = 1'b0; a0 = '0; b0 = '0;
    rst1 = 1'b1; start1 = 1'b0; acc1 = 1'b0; a1 = '0; b1 = '0;
    fork
      run0();
      run1();
    join
    chk("q0_drained", 128'(exp_q0.size()), 128'd0);
    chk("q1_drained", 128'(exp_q1.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
